// File: rtl/trig_result_aligner.sv
// trig_result_aligner: pairs each argument issued to a fixed-latency trig core
// with the result that core returns LATENCY cycles later. Keeps in-flight,
// issue and retire bookkeeping.
// Optional feature macro: TRIG_ALIGN_ULPCHK_EN adds a per-channel ULP checker
// against io_ref. Without it io_mismatch and io_err_count are tied to zero.
module trig_result_aligner #(
  parameter int WIDTH    = 32,
  parameter int EXP_W    = 8,
  parameter int LATENCY  = 46,
  parameter int CHANNELS = 2,
  parameter int MAX_ULP  = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      io_in_valid,
  input  logic [WIDTH-1:0]          io_in,
  input  logic                      io_flush,
  input  logic [CHANNELS*WIDTH-1:0] io_dut_out,
  input  logic [CHANNELS*WIDTH-1:0] io_ref,
  output logic                      io_out_valid,
  output logic [WIDTH-1:0]          io_out_arg,
  output logic [CHANNELS*WIDTH-1:0] io_out_res,
  output logic                      io_busy,
  output logic [15:0]               io_issued,
  output logic [15:0]               io_retired,
  output logic [CHANNELS-1:0]       io_mismatch,
  output logic [15:0]               io_err_count
);

  localparam int PTR_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(LATENCY - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   wp, wp_next;
  logic [LATENCY-1:0] slot_valid, valid_next;
  logic [WIDTH-1:0]   slot_arg [LATENCY];
  logic [CNT_W-1:0]   count, count_next;
  logic               rd_hit;
  logic               emit;

  // Slot wp holds the entry written LATENCY cycles ago; read it, then overwrite.
  always_comb begin
    rd_hit     = slot_valid[wp];
    emit       = rd_hit & ~io_flush;
    valid_next = io_flush ? '0 : slot_valid;
    valid_next[wp] = io_in_valid;
    wp_next    = (wp == LAST_SLOT) ? '0 : wp + PTR_W'(1);
  end

  // In-flight count: a flush empties the pipe, then a same-cycle accept counts as one.
  always_comb begin
    count_next = count;
    if (io_flush) begin
      count_next = io_in_valid ? CNT_W'(1) : '0;
    end else if (io_in_valid && !rd_hit) begin
      count_next = count + CNT_W'(1);
    end else if (!io_in_valid && rd_hit) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Busy FSM: leaves IDLE on an accept, returns once the pipe has drained.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count_next != '0) state_next = ACTIVE;
      ACTIVE:  if (count_next == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register for the FSM, count and write pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      wp    <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      wp    <= wp_next;
    end
  end

  // Slot valid bits; reset drops every in-flight entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid <= '0;
    end else begin
      slot_valid <= valid_next;
    end
  end

  // Argument storage is pure data and is only meaningful under its valid bit.
  always_ff @(posedge clock) begin
    slot_arg[wp] <= io_in;
  end

  // Registered aligned output plus issue/retire counters (wrap modulo 2^16).
  always_ff @(posedge clock) begin
    if (reset) begin
      io_out_valid <= 1'b0;
      io_out_arg   <= '0;
      io_out_res   <= '0;
      io_issued    <= '0;
      io_retired   <= '0;
    end else begin
      io_out_valid <= emit;
      if (emit) begin
        io_out_arg <= slot_arg[wp];
        io_out_res <= io_dut_out;
      end
      if (io_in_valid) io_issued  <= io_issued + 16'd1;
      if (emit)        io_retired <= io_retired + 16'd1;
    end
  end

  assign io_busy = (state == ACTIVE);

`ifdef TRIG_ALIGN_ULPCHK_EN
  logic [CHANNELS-1:0] ch_bad;
  logic [WIDTH-1:0]    chk_d, chk_r;
  logic [WIDTH:0]      chk_diff, chk_dist;

  // Sign-magnitude to two's-complement ordering key; +0 and -0 both land on 0.
  function automatic logic [WIDTH:0] ord_key(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] mag;
    mag = {2'b00, v[WIDTH-2:0]};
    return v[WIDTH-1] ? ((WIDTH+1)'(0) - mag) : mag;
  endfunction

  function automatic logic is_nan(input logic [WIDTH-1:0] v);
    return (&v[WIDTH-2 -: EXP_W]) && (|v[WIDTH-2-EXP_W:0]);
  endfunction

  // Per-channel ULP distance; two NaNs agree, a single NaN never does.
  always_comb begin
    ch_bad   = '0;
    chk_d    = '0;
    chk_r    = '0;
    chk_diff = '0;
    chk_dist = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      chk_d    = io_dut_out[ch*WIDTH +: WIDTH];
      chk_r    = io_ref[ch*WIDTH +: WIDTH];
      chk_diff = ord_key(chk_d) - ord_key(chk_r);
      chk_dist = chk_diff[WIDTH] ? ((WIDTH+1)'(0) - chk_diff) : chk_diff;
      if (is_nan(chk_d) && is_nan(chk_r)) begin
        ch_bad[ch] = 1'b0;
      end else if (is_nan(chk_d) || is_nan(chk_r)) begin
        ch_bad[ch] = 1'b1;
      end else begin
        ch_bad[ch] = (chk_dist > (WIDTH+1)'(MAX_ULP));
      end
    end
  end

  // Mismatch flags ride with io_out_valid; the error total follows a cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      io_mismatch  <= '0;
      io_err_count <= '0;
    end else begin
      io_mismatch <= emit ? ch_bad : '0;
      if (io_out_valid && (|io_mismatch) && (io_err_count != 16'hFFFF)) begin
        io_err_count <= io_err_count + 16'd1;
      end
    end
  end
`else
  localparam int unused_cfg = EXP_W + MAX_ULP;
  logic unused_ref;
  assign unused_ref   = ^io_ref;
  assign io_mismatch  = '0;
  assign io_err_count = '0;
`endif

endmodule

// File: tb/tb_trig_result_aligner.sv
// tb_trig_result_aligner: directed and random stimulus against a cycle-indexed
// reference model of the aligner (entry k emerges at cycle k+47 unless killed).
module tb_trig_result_aligner;

  localparam int WIDTH    = 32;
  localparam int CHANNELS = 2;
  localparam int LATENCY  = 46;
  localparam int OUT_LAT  = LATENCY + 1;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      io_in_valid;
  logic [WIDTH-1:0]          io_in;
  logic                      io_flush;
  logic [CHANNELS*WIDTH-1:0] io_dut_out;
  logic [CHANNELS*WIDTH-1:0] io_ref;
  logic                      io_out_valid;
  logic [WIDTH-1:0]          io_out_arg;
  logic [CHANNELS*WIDTH-1:0] io_out_res;
  logic                      io_busy;
  logic [15:0]               io_issued;
  logic [15:0]               io_retired;
  logic [CHANNELS-1:0]       io_mismatch;
  logic [15:0]               io_err_count;

  trig_result_aligner #(
    .WIDTH(WIDTH), .EXP_W(8), .LATENCY(LATENCY), .CHANNELS(CHANNELS), .MAX_ULP(4)
  ) dut (
    .clock(clock), .reset(reset), .io_in_valid(io_in_valid), .io_in(io_in),
    .io_flush(io_flush), .io_dut_out(io_dut_out), .io_ref(io_ref),
    .io_out_valid(io_out_valid), .io_out_arg(io_out_arg), .io_out_res(io_out_res),
    .io_busy(io_busy), .io_issued(io_issued), .io_retired(io_retired),
    .io_mismatch(io_mismatch), .io_err_count(io_err_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Model state: input history ring plus the most recent reset/flush cycles.
  int          t = 0;
  bit          hv [128];
  logic [31:0] ha [128];
  int          last_rst = -1;
  int          last_flush = -1000;
  logic [63:0] prev_dut = '0, prev_ref = '0;
  bit          exp_valid = 0, prev_exp_valid = 0, exp_busy;
  logic [31:0] exp_arg = '0;
  logic [63:0] exp_res = '0;
  logic [15:0] exp_issued = '0, exp_retired = '0, exp_err = '0;
  logic [1:0]  exp_mis = '0, prev_exp_mis = '0;
  bit          do_check = 1;
  bit          jitter = 0;
  bit          ovr_en = 0;
  logic [63:0] ovr_dut = '0, ovr_ref = '0;
  int          pulses = 0;

  // Stand-in core: a pure function of the argument, channel 0 in the LSBs.
  function automatic logic [63:0] stub(input logic [31:0] a);
    return {a + 32'h1, a ^ 32'hA5A5A5A5};
  endfunction

  function automatic bit ulp_bad(input logic [31:0] d, input logic [31:0] r);
`ifdef TRIG_ALIGN_ULPCHK_EN
    longint kd, kr, dist;
    bit nd, nr;
    nd = (d[30:23] == 8'hFF) && (d[22:0] != 0);
    nr = (r[30:23] == 8'hFF) && (r[22:0] != 0);
    kd = d[31] ? -longint'(d[30:0]) : longint'(d[30:0]);
    kr = r[31] ? -longint'(r[30:0]) : longint'(r[30:0]);
    dist = kd - kr;
    if (dist < 0) dist = -dist;
    if (nd && nr) return 1'b0;
    if (nd || nr) return 1'b1;
    return dist > 4;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [1:0] mis_vec(input logic [63:0] d, input logic [63:0] r);
    return {ulp_bad(d[63:32], r[63:32]), ulp_bad(d[31:0], r[31:0])};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  // One clock cycle: check this cycle's outputs against the model, then drive inputs.
  task automatic applyStimulus(input bit v, input logic [31:0] a, input bit f, input bit r);
    int k;
    int alive;
    logic [63:0] dut_v, ref_v;
    @(posedge clock);
    #1;
    k = t - OUT_LAT;
    if (last_rst == t - 1) begin
      exp_valid = 0; exp_arg = '0; exp_res = '0;
      exp_retired = '0; exp_mis = '0; exp_err = '0;
    end else begin
      if (prev_exp_valid && (prev_exp_mis != 0) && (exp_err != 16'hFFFF)) exp_err++;
      exp_valid = (k >= 0) && hv[k % 128] && (last_rst < k) && (last_flush <= k);
      if (exp_valid) begin
        exp_arg = ha[k % 128];
        exp_res = prev_dut;
        exp_retired++;
      end
      exp_mis = exp_valid ? mis_vec(prev_dut, prev_ref) : 2'b00;
    end
    alive = 0;
    for (int j = 1; j <= LATENCY; j++) begin
      int kk;
      kk = t - j;
      if (kk >= 0 && hv[kk % 128] && last_rst < kk && last_flush <= kk) alive++;
    end
    exp_busy = (alive != 0);
    if (io_out_valid) pulses++;
    if (do_check) begin
      checkOutput("out_valid", 64'(io_out_valid), 64'(exp_valid));
      checkOutput("out_arg", 64'(io_out_arg), 64'(exp_arg));
      checkOutput("out_res", io_out_res, exp_res);
      checkOutput("busy", 64'(io_busy), 64'(exp_busy));
      checkOutput("issued", 64'(io_issued), 64'(exp_issued));
      checkOutput("retired", 64'(io_retired), 64'(exp_retired));
      checkOutput("mismatch", 64'(io_mismatch), 64'(exp_mis));
      checkOutput("err_count", 64'(io_err_count), 64'(exp_err));
    end
    dut_v = (t >= LATENCY) ? stub(ha[(t - LATENCY) % 128]) : stub('0);
    ref_v = dut_v;
    if (jitter) begin
      ref_v[31:0]  = ref_v[31:0]  + 32'($urandom_range(0, 6));
      ref_v[63:32] = ref_v[63:32] + 32'($urandom_range(0, 6));
    end
    if (ovr_en) begin
      dut_v = ovr_dut;
      ref_v = ovr_ref;
    end
    reset = r; io_in_valid = v; io_in = a; io_flush = f;
    io_dut_out = dut_v; io_ref = ref_v;
    hv[t % 128] = v; ha[t % 128] = a;
    prev_dut = dut_v; prev_ref = ref_v;
    prev_exp_valid = exp_valid; prev_exp_mis = exp_mis;
    if (r) begin
      last_rst = t;
      exp_issued = '0;
    end else begin
      if (f) last_flush = t;
      if (v) exp_issued++;
    end
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, $urandom, 0, 0);
  endtask

  // One ULP case: issue an arg, then present chosen dut/ref values 46 cycles later.
  task automatic ulpCase(input logic [63:0] d, input logic [63:0] r);
    applyStimulus(1, $urandom, 0, 0);
    idle(LATENCY - 1);
    ovr_en = 1; ovr_dut = d; ovr_ref = r;
    applyStimulus(0, '0, 0, 0);
    ovr_en = 0;
    applyStimulus(0, '0, 0, 0);
  endtask

  initial begin
    reset = 1; io_in_valid = 0; io_in = '0; io_flush = 0; io_dut_out = '0; io_ref = '0;

    applyStimulus(0, '0, 0, 1);
    applyStimulus(0, '0, 0, 1);
    applyStimulus(0, '0, 0, 0);

    // Back-to-back 0x00..0x40
    for (int i = 0; i <= 64; i++) applyStimulus(1, 32'(i), 0, 0);
    idle(50);
    checkOutput("b2b_retired", 64'(io_retired), 64'd65);

    // Gapped issue at relative cycles 0, 3, 45
    pulses = 0;
    for (int i = 0; i <= 105; i++)
      applyStimulus((i == 0 || i == 3 || i == 45), 32'h100 + 32'(i), 0, 0);
    checkOutput("gap_pulses", 64'(pulses), 64'd3);

    // Flush with concurrent issue after 10 in flight
    pulses = 0;
    for (int i = 0; i <= 80; i++)
      applyStimulus((i < 10 || i == 20), 32'h200 + 32'(i), (i == 20), 0);
    checkOutput("flush_pulses", 64'(pulses), 64'd1);

    // Reset with 30 in flight
    for (int i = 0; i < 30; i++) applyStimulus(1, 32'h300 + 32'(i), 0, 0);
    applyStimulus(0, '0, 0, 1);
    pulses = 0;
    idle(90);
    checkOutput("rst_pulses", 64'(pulses), 64'd0);
    checkOutput("rst_issued", 64'(io_issued), 64'd0);
    checkOutput("rst_retired", 64'(io_retired), 64'd0);

    // ULP cases: +5 ULP on ch1, +0 vs -0, NaN vs 1.0, +4 ULP, across zero
    ulpCase({32'h3F800000, 32'h3F800000}, {32'h3F800005, 32'h3F800000});
`ifdef TRIG_ALIGN_ULPCHK_EN
    checkOutput("ulp5_mis", 64'(io_mismatch), 64'h2);
    applyStimulus(0, '0, 0, 0);
    checkOutput("ulp5_err", 64'(io_err_count), 64'd1);
`else
    checkOutput("ulp5_mis", 64'(io_mismatch), 64'h0);
    applyStimulus(0, '0, 0, 0);
    checkOutput("ulp5_err", 64'(io_err_count), 64'd0);
`endif
    ulpCase({32'h00000000, 32'h80000000}, {32'h80000000, 32'h00000000});
    checkOutput("zero_mis", 64'(io_mismatch), 64'h0);
    ulpCase({32'h3F800000, 32'h7FC00000}, {32'h3F800000, 32'h3F800000});
    ulpCase({32'h3F800004, 32'h00000002}, {32'h3F800000, 32'h80000002});
    ulpCase({32'h7FC00001, 32'h00000003}, {32'h7FA00000, 32'h80000002});
    idle(2);

    // Random traffic with flushes, resets and ref jitter
    jitter = 1;
    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 99) == 0);
    jitter = 0;
    idle(50);

    // Counter wrap: 70000 accepts after a reset
    applyStimulus(0, '0, 0, 1);
    do_check = 0;
    for (int i = 0; i < 70000; i++) applyStimulus(1, $urandom, 0, 0);
    applyStimulus(0, '0, 0, 0);
    checkOutput("wrap_issued", 64'(io_issued), 64'd4464);
    do_check = 1;
    idle(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
